// File: rtl/piped_alu_fwd.sv
// piped_alu_fwd -- 3-stage (RD / EX / WB) pipelined ALU with an internal
// register bank, full operand forwarding and a direct register-load port.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears bank, pipeline and outputs
//   in_valid   issue qualifier for rs1/rs2/rd/opcode
//   rs1, rs2   source register indices (AW bits)
//   rd         destination register index (AW bits)
//   opcode     4-bit operation; 12-15 are reserved and raise err
//   ld_en      direct register-load strobe (ld_addr, ld_data)
//   Out        writeback result, holds across bubbles
//   out_valid  one-cycle pulse per retired instruction
//   zero       Out == 0, registered alongside Out
//   carry      carry / borrow / shifted-out bit / multiply overflow
//   err        reserved opcode retired
//
// An op sampled at edge E0 has its operands in the RD registers after E0,
// its result in the EX register after E1 and is written back at E2.
module piped_alu_fwd #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [3:0]       opcode,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOTA = 4'd6;
    localparam logic [3:0] OP_NOTB = 4'd7;
    localparam logic [3:0] OP_SELA = 4'd8;
    localparam logic [3:0] OP_SELB = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;

    logic [WIDTH-1:0] regs_q [NREGS];

    // vld_pipe_q[0]: op in RD regs, [1]: op in EX reg, [2]: retired (out_valid)
    logic [2:0]       vld_pipe_q;

    // RD stage registers
    logic [3:0]       s1_op_q;
    logic [AW-1:0]    s1_dst_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;

    // EX stage registers
    logic [AW-1:0]    s2_dst_q;
    logic [WIDTH-1:0] s2_res_q;
    logic             s2_carry_q, s2_err_q;

    // WB / output registers
    logic [WIDTH-1:0] out_q;
    logic             zero_q, carry_q, err_q;

    // EX combinational result
    logic [WIDTH-1:0]   ex_res_d;
    logic               ex_carry_d, ex_err_d;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        ex_res_d   = '0;
        ex_carry_d = 1'b0;
        ex_err_d   = 1'b0;
        prod       = '0;
        case (s1_op_q)
            OP_ADD:  {ex_carry_d, ex_res_d} = {1'b0, s1_a_q} + {1'b0, s1_b_q};
            // the extra top bit of the (WIDTH+1)-bit difference is the borrow
            OP_SUB:  {ex_carry_d, ex_res_d} = {1'b0, s1_a_q} - {1'b0, s1_b_q};
            OP_MUL: begin
                prod       = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
                ex_res_d   = prod[WIDTH-1:0];
                ex_carry_d = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  ex_res_d = s1_a_q & s1_b_q;
            OP_OR:   ex_res_d = s1_a_q | s1_b_q;
            OP_XOR:  ex_res_d = s1_a_q ^ s1_b_q;
            OP_NOTA: ex_res_d = ~s1_a_q;
            OP_NOTB: ex_res_d = ~s1_b_q;
            OP_SELA: ex_res_d = s1_a_q;
            OP_SELB: ex_res_d = s1_b_q;
            OP_SHR: begin
                ex_res_d   = {1'b0, s1_a_q[WIDTH-1:1]};
                ex_carry_d = s1_a_q[0];
            end
            OP_SHL: begin
                ex_res_d   = {s1_a_q[WIDTH-2:0], 1'b0};
                ex_carry_d = s1_a_q[WIDTH-1];
            end
            default: ex_err_d = 1'b1;  // reserved: result 0, no carry
        endcase
    end

    // Forwarding sources: only valid, non-reserved ops ever write the bank.
    logic ex_fwd_ok, wb_fwd_ok;
    assign ex_fwd_ok = vld_pipe_q[0] & ~ex_err_d;
    assign wb_fwd_ok = vld_pipe_q[1] & ~s2_err_q;

    // The WB source covers the op writing the bank at this very edge, so the
    // bank read never needs write-through. Youngest source is applied last.
    logic [WIDTH-1:0] opa_d, opb_d;

    always_comb begin
        opa_d = regs_q[rs1];
        if (wb_fwd_ok && s2_dst_q == rs1) opa_d = s2_res_q;
        if (ex_fwd_ok && s1_dst_q == rs1) opa_d = ex_res_d;
        opb_d = regs_q[rs2];
        if (wb_fwd_ok && s2_dst_q == rs2) opb_d = s2_res_q;
        if (ex_fwd_ok && s1_dst_q == rs2) opb_d = ex_res_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            vld_pipe_q <= '0;
            s1_op_q    <= '0;
            s1_dst_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_dst_q   <= '0;
            s2_res_q   <= '0;
            s2_carry_q <= 1'b0;
            s2_err_q   <= 1'b0;
            out_q      <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], in_valid};

            // RD capture is unconditional; vld_pipe_q qualifies it downstream
            s1_op_q  <= opcode;
            s1_dst_q <= rd;
            s1_a_q   <= opa_d;
            s1_b_q   <= opb_d;

            s2_dst_q   <= s1_dst_q;
            s2_res_q   <= ex_res_d;
            s2_carry_q <= ex_carry_d;
            s2_err_q   <= ex_err_d;

            // bubbles leave Out and flags untouched
            if (vld_pipe_q[1]) begin
                out_q   <= s2_res_q;
                zero_q  <= (s2_res_q == '0);
                carry_q <= s2_carry_q;
                err_q   <= s2_err_q;
            end

            // load first so a same-edge writeback to the same address wins
            if (ld_en) regs_q[ld_addr] <= ld_data;
            if (wb_fwd_ok) regs_q[s2_dst_q] <= s2_res_q;
        end
    end

    assign Out       = out_q;
    assign out_valid = vld_pipe_q[2];
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_piped_alu_fwd.sv
module tb_piped_alu_fwd;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] rs1, rs2, rd, ld_addr;
    logic [3:0] opcode;
    logic       ld_en;
    logic [7:0] ld_data;
    logic [7:0] Out;
    logic       out_valid, zero, carry, err;

    // 16-bit, 16-register instance
    logic        w_in_valid;
    logic [3:0]  w_rs1, w_rs2, w_rd, w_ld_addr, w_opcode;
    logic        w_ld_en;
    logic [15:0] w_ld_data;
    logic [15:0] w_Out;
    logic        w_out_valid, w_zero, w_carry, w_err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    piped_alu_fwd #(.WIDTH(8), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .Out(Out), .out_valid(out_valid), .zero(zero), .carry(carry), .err(err)
    );

    piped_alu_fwd #(.WIDTH(16), .NREGS(16)) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_in_valid),
        .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .opcode(w_opcode),
        .ld_en(w_ld_en), .ld_addr(w_ld_addr), .ld_data(w_ld_data),
        .Out(w_Out), .out_valid(w_out_valid), .zero(w_zero), .carry(w_carry), .err(w_err)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a, b;
        logic [7:0] e_out;
        logic       e_c, e_z, e_e;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        in_valid = 1'b1;
        opcode   = op;
        rd       = d;
        rs1      = a;
        rs2      = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic load_idx();
        for (int i = 0; i < 8; i++) load(3'(i), 8'(i));
    endtask

    task automatic expect_out(input string nm, input logic [7:0] o, input logic c, input logic z, input logic e);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".out"},   32'(Out),       32'(o));
        chk({nm, ".carry"}, 32'(carry),     32'(c));
        chk({nm, ".zero"},  32'(zero),      32'(z));
        chk({nm, ".err"},   32'(err),       32'(e));
    endtask

    // read a register back through SEL A, writing it onto itself
    task automatic readback(input logic [2:0] r, input logic [7:0] exp, input string nm);
        issue(4'd8, r, r, 3'd0);
        tick();
        idle();
        tick();
        tick();
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".val"},   32'(Out),       32'(exp));
        chk({nm, ".err"},   32'(err),       32'd0);
    endtask

    // Reference ALU in plain integer arithmetic for an 8-bit datapath
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int c, output int e);
        res = 0; c = 0; e = 0;
        case (op)
            0:  begin res = (a + b) % 256;        c = (a + b > 255) ? 1 : 0; end
            1:  begin res = (a - b + 256) % 256;  c = (a < b) ? 1 : 0; end
            2:  begin res = (a * b) % 256;        c = (a * b > 255) ? 1 : 0; end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = 255 - a;
            7:  res = 255 - b;
            8:  res = a;
            9:  res = b;
            10: begin res = a / 2;                c = a % 2; end
            11: begin res = (a * 2) % 256;        c = (a >= 128) ? 1 : 0; end
            default: e = 1;
        endcase
    endfunction

    localparam int NRND = 400;
    int  arch [8];
    bit  r_iv [NRND];
    int  r_out [NRND], r_c [NRND], r_e [NRND];

    initial begin
        reset = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; opcode = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        w_in_valid = 1'b0; w_rs1 = '0; w_rs2 = '0; w_rd = '0; w_opcode = '0;
        w_ld_en = 1'b0; w_ld_addr = '0; w_ld_data = '0;

        vecs.push_back('{"add_c",   4'd0,  8'd200, 8'd100, 8'd44,  1, 0, 0});
        vecs.push_back('{"add",     4'd0,  8'd1,   8'd2,   8'd3,   0, 0, 0});
        vecs.push_back('{"add_z",   4'd0,  8'd128, 8'd128, 8'd0,   1, 1, 0});
        vecs.push_back('{"sub_b",   4'd1,  8'd100, 8'd200, 8'd156, 1, 0, 0});
        vecs.push_back('{"sub_z",   4'd1,  8'd5,   8'd5,   8'd0,   0, 1, 0});
        vecs.push_back('{"mul_ov",  4'd2,  8'd16,  8'd16,  8'd0,   1, 1, 0});
        vecs.push_back('{"mul",     4'd2,  8'd15,  8'd17,  8'd255, 0, 0, 0});
        vecs.push_back('{"and",     4'd3,  8'hF0,  8'h3C,  8'h30,  0, 0, 0});
        vecs.push_back('{"or",      4'd4,  8'hF0,  8'h0F,  8'hFF,  0, 0, 0});
        vecs.push_back('{"xor_z",   4'd5,  8'hAA,  8'hAA,  8'h00,  0, 1, 0});
        vecs.push_back('{"nota",    4'd6,  8'h0F,  8'h33,  8'hF0,  0, 0, 0});
        vecs.push_back('{"notb",    4'd7,  8'h12,  8'hFF,  8'h00,  0, 1, 0});
        vecs.push_back('{"sela",    4'd8,  8'h5A,  8'h11,  8'h5A,  0, 0, 0});
        vecs.push_back('{"selb",    4'd9,  8'h11,  8'hA5,  8'hA5,  0, 0, 0});
        vecs.push_back('{"shr",     4'd10, 8'h81,  8'h00,  8'h40,  1, 0, 0});
        vecs.push_back('{"shl",     4'd11, 8'h81,  8'h00,  8'h02,  1, 0, 0});
        vecs.push_back('{"shl_nc",  4'd11, 8'h40,  8'h00,  8'h80,  0, 0, 0});
        vecs.push_back('{"rsv13",   4'd13, 8'h12,  8'h34,  8'h00,  0, 1, 1});
        vecs.push_back('{"rsv15",   4'd15, 8'hFF,  8'hFF,  8'h00,  0, 1, 1});

        // ---- reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst.out",   32'(Out),       32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.zero",  32'(zero),      32'd0);
        chk("rst.carry", 32'(carry),     32'd0);
        chk("rst.err",   32'(err),       32'd0);

        // ---- basic issue-to-WB latency and bubble hold
        load_idx();
        issue(4'd0, 3'd1, 3'd1, 3'd2);
        tick();
        idle();
        tick();
        chk("t1.e1_valid", 32'(out_valid), 32'd0);
        tick();
        expect_out("t1", 8'd3, 0, 0, 0);
        tick();
        chk("t1.pulse_end", 32'(out_valid), 32'd0);
        chk("t1.hold",      32'(Out),       32'd3);

        // ---- back-to-back dependent ops
        load_idx();
        issue(4'd0, 3'd1, 3'd1, 3'd2); tick();
        issue(4'd1, 3'd2, 3'd1, 3'd0); tick();
        issue(4'd2, 3'd3, 3'd1, 3'd2); tick();
        idle();
        expect_out("t2.add", 8'd3, 0, 0, 0); tick();
        expect_out("t2.sub", 8'd3, 0, 0, 0); tick();
        expect_out("t2.mul", 8'd9, 0, 0, 0);
        readback(3'd1, 8'd3, "t2.r1");
        readback(3'd2, 8'd3, "t2.r2");
        readback(3'd3, 8'd9, "t2.r3");

        // ---- flags
        load(3'd4, 8'd200);
        load(3'd5, 8'd100);
        issue(4'd0, 3'd6, 3'd4, 3'd5); tick();
        issue(4'd1, 3'd7, 3'd5, 3'd5); tick();
        issue(4'd1, 3'd0, 3'd5, 3'd4); tick();
        idle();
        expect_out("t3.add", 8'd44,  1, 0, 0); tick();
        expect_out("t3.sub", 8'd0,   0, 1, 0); tick();
        expect_out("t3.bor", 8'd156, 1, 0, 0);

        // ---- reserved opcode must not write the bank
        issue(4'd13, 3'd2, 3'd0, 3'd0); tick();
        idle(); tick(); tick();
        expect_out("t4.rsv", 8'd0, 0, 1, 1);
        readback(3'd2, 8'd3, "t4.r2");

        // ---- load is not forwarded to an op sampled at the same edge
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 8'd7;
        issue(4'd8, 3'd5, 3'd4, 3'd0);
        tick();
        ld_en = 1'b0; idle();
        tick(); tick();
        expect_out("ld.nofwd", 8'd200, 0, 0, 0);
        readback(3'd4, 8'd7, "ld.newval");

        // ---- same-edge load and WB to one register: WB wins
        issue(4'd0, 3'd1, 3'd1, 3'd2); tick();
        idle(); tick();
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h55;
        tick();
        ld_en = 1'b0;
        expect_out("ld.wbwin", 8'd6, 0, 0, 0);
        readback(3'd1, 8'd6, "ld.wbwin_r1");

        // ---- load landing before a pending WB is overwritten by it
        issue(4'd0, 3'd3, 3'd1, 3'd1); tick();
        idle();
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 8'h11;
        tick();
        ld_en = 1'b0;
        tick();
        expect_out("ld.pend", 8'd12, 0, 0, 0);
        readback(3'd3, 8'd12, "ld.pend_r3");

        // ---- table vectors: load A into r1, B into r2, r3 = A op B
        foreach (vecs[i]) begin
            load(3'd1, vecs[i].a);
            load(3'd2, vecs[i].b);
            issue(vecs[i].op, 3'd3, 3'd1, 3'd2);
            tick();
            idle();
            tick(); tick();
            expect_out({"vec.", vecs[i].name}, vecs[i].e_out, vecs[i].e_c, vecs[i].e_z, vecs[i].e_e);
        end

        // ---- 16-bit instance: shifts and WB-over-load
        w_ld_en = 1'b1; w_ld_addr = 4'd15; w_ld_data = 16'h8001;
        tick();
        w_ld_en = 1'b0;
        w_in_valid = 1'b1; w_opcode = 4'd11; w_rs1 = 4'd15; w_rs2 = 4'd0; w_rd = 4'd14;
        tick();
        w_opcode = 4'd10; w_rd = 4'd13;
        tick();
        w_opcode = 4'd0; w_rs1 = 4'd15; w_rs2 = 4'd15; w_rd = 4'd12;
        tick();
        w_in_valid = 1'b0;
        chk("w.shl.valid", 32'(w_out_valid), 32'd1);
        chk("w.shl.out",   32'(w_Out),       32'h0002);
        chk("w.shl.carry", 32'(w_carry),     32'd1);
        tick();
        chk("w.shr.out",   32'(w_Out),       32'h4000);
        chk("w.shr.carry", 32'(w_carry),     32'd1);
        w_ld_en = 1'b1; w_ld_addr = 4'd12; w_ld_data = 16'hBEEF;
        tick();
        w_ld_en = 1'b0;
        chk("w.add.out",   32'(w_Out),       32'h0002);
        w_in_valid = 1'b1; w_opcode = 4'd8; w_rs1 = 4'd12; w_rd = 4'd11;
        tick();
        w_in_valid = 1'b0;
        tick(); tick();
        chk("w.wbwin.valid", 32'(w_out_valid), 32'd1);
        chk("w.wbwin.r12",   32'(w_Out),       32'h0002);

        // ---- reset with ops in flight; load ignored during reset
        issue(4'd0, 3'd1, 3'd1, 3'd2); tick();
        issue(4'd1, 3'd2, 3'd1, 3'd2); tick();
        idle();
        reset = 1'b1;
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'h77;
        tick();
        reset = 1'b0; ld_en = 1'b0;
        chk("t5.out0", 32'(Out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t5.novalid", 32'(out_valid), 32'd0);
            chk("t5.out",     32'(Out),       32'd0);
            tick();
        end
        for (int r = 0; r < 8; r++) readback(3'(r), 8'd0, "t5.clear");

        // ---- randomized program against an in-order reference model
        reset = 1'b1; tick(); reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            arch[r] = int'($urandom_range(255));
            load(3'(r), 8'(arch[r]));
        end
        begin
            int lo, lc, lz, le, res, c, e, a, b, d, op;
            lo = 0; lc = 0; lz = 0; le = 0;
            for (int t = 0; t < NRND + 2; t++) begin
                if (t < NRND && $urandom_range(3) != 0) begin
                    a  = int'($urandom_range(7));
                    b  = int'($urandom_range(7));
                    d  = int'($urandom_range(7));
                    op = int'($urandom_range(15));
                    ref_alu(op, arch[a], arch[b], res, c, e);
                    if (e == 0) arch[d] = res;
                    r_iv[t] = 1'b1; r_out[t] = res; r_c[t] = c; r_e[t] = e;
                    issue(4'(op), 3'(d), 3'(a), 3'(b));
                end else begin
                    if (t < NRND) r_iv[t] = 1'b0;
                    idle();
                end
                tick();
                if (t >= 2 && r_iv[t-2]) begin
                    lo = r_out[t-2]; lc = r_c[t-2]; le = r_e[t-2];
                    lz = (r_out[t-2] == 0) ? 1 : 0;
                end
                chk("rnd.valid", 32'(out_valid), (t >= 2 && r_iv[t-2]) ? 32'd1 : 32'd0);
                chk("rnd.out",   32'(Out),       32'(lo));
                chk("rnd.carry", 32'(carry),     32'(lc));
                chk("rnd.zero",  32'(zero),      32'(lz));
                chk("rnd.err",   32'(err),       32'(le));
            end
            for (int r = 0; r < 8; r++) readback(3'(r), 8'(arch[r]), "rnd.bank");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
